// File: rtl/apple1_pkg.sv
// rtl/apple1_pkg.sv - shared Apple-1 constants and RAM arbiter state encoding
package apple1_pkg;

    localparam int CPU_CLK_DIV = 25;
    localparam int RAM_AW      = 13;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - DMA requester req/ack/rvalid handshake bundle
interface ram_arbiter_if
    import apple1_pkg::*;
#(
    parameter int AW = RAM_AW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          ack;
    logic          rvalid;
    logic [7:0]    rdata;

    // Requester side: issues accesses, receives ack and read data.
    modport master (
        output req, we, addr, din,
        input  ack, rvalid, rdata
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, din,
        output ack, rvalid, rdata
    );
endinterface

// File: rtl/clken_phase.sv
// rtl/clken_phase.sv - phase tracker for the CPU clock-enable cadence and CPU ownership window
module clken_phase #(
    parameter int PERIOD = 25,
    parameter int GUARD  = 2
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic cpu_clken,
    output logic cpu_owns
);
    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] PHASE_MAX  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] OWN_START  = PW'(PERIOD - 1 - GUARD);

    logic [PW-1:0] phase;

    // Phase restarts on every enable (early ones included) and saturates at the enable slot.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            phase <= PHASE_MAX;
        end else if (cpu_clken) begin
            phase <= '0;
        end else if (phase != PHASE_MAX) begin
            phase <= phase + 1'b1;
        end
    end

    // The guard slots plus the enable slot belong to the CPU.
    always_comb begin
        cpu_owns = (phase >= OWN_START);
    end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the system RAM port between the 6502 and one DMA requester
module ram_arbiter
    import apple1_pkg::*;
#(
    parameter int PERIOD = CPU_CLK_DIV,
    parameter int GUARD  = 2,
    parameter int AW     = RAM_AW
) (
    input  logic          clk25,
    input  logic          rst_n,
    input  logic          cpu_clken,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_din,
    ram_arbiter_if.slave  dma,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic          cpu_owns
);
    arb_state_e state_q;
    arb_state_e state_d;
    logic [7:0] rdata_q;
    logic       grant;

    clken_phase #(
        .PERIOD (PERIOD),
        .GUARD  (GUARD)
    ) u_phase (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .cpu_clken (cpu_clken),
        .cpu_owns  (cpu_owns)
    );

    // State register and held read data.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_RD_WAIT) begin
                rdata_q <= ram_dout;
            end
        end
    end

    // Grant decision, RAM port mux and handshake outputs; reset masks any pending completion.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        dma.ack    = 1'b0;
        dma.rvalid = 1'b0;
        dma.rdata  = rdata_q;
        ram_addr   = cpu_addr;
        ram_din    = cpu_din;
        ram_we     = cpu_owns & cpu_we & cpu_cs;

        unique case (state_q)
            ARB_IDLE: begin
                grant = rst_n & dma.req & ~cpu_owns;
                if (grant) begin
                    ram_addr = dma.addr;
                    ram_din  = dma.din;
                    ram_we   = dma.we;
                    dma.ack  = 1'b1;
                    if (!dma.we) begin
                        state_d = ARB_RD_WAIT;
                    end
                end
            end
            ARB_RD_WAIT: begin
                // Port is free for the CPU mux here; the RAM returns the previous cycle's read.
                state_d = ARB_IDLE;
                if (rst_n) begin
                    dma.rvalid = 1'b1;
                    dma.rdata  = ram_dout;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
module tb_ram_arbiter;
    import apple1_pkg::*;

    typedef struct {
        int         phase;
        logic       we;
        logic [12:0] addr;
        logic [7:0] din;
    } ack_exp_t;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        cpu_clken;
    logic [12:0] cpu_addr;
    logic        cpu_cs;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        cpu_owns;

    ram_arbiter_if #(.AW(13)) dma ();

    ram_arbiter #(.PERIOD(25), .GUARD(2), .AW(13)) dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .cpu_clken (cpu_clken),
        .cpu_addr  (cpu_addr),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_din   (cpu_din),
        .dma       (dma),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .cpu_owns  (cpu_owns)
    );

    always #20 clk25 = ~clk25;

    int n_pass = 0;
    int n_total = 0;

    ack_exp_t   ack_q[$];
    logic [7:0] rd_q[$];

    logic [7:0] exp_cpu_rd = 8'h5A;
    logic       gen_en = 1'b0;
    int         gen_cnt = 0;
    logic       seen = 1'b0;
    logic       init_done = 1'b0;
    logic       prev_ack_read = 1'b0;

    logic [7:0] mem [0:8191];

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] preload_val(input int a);
        if (a == 'h123) return 8'h5A;
        if (a >= 'h200 && a <= 'h20B) return 8'((a - 'h200) * 7 + 3);
        return 8'h00;
    endfunction

    // Synchronous RAM with one-cycle registered read.
    always @(posedge clk25) begin
        if (!init_done) begin
            for (int i = 0; i < 8192; i++) mem[i] <= preload_val(i);
            init_done <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    // CPU enable generator; after the first enable the arbiter phase equals gen_cnt.
    assign cpu_clken = gen_en && (gen_cnt == 24);
    always @(posedge clk25) begin
        if (!gen_en) gen_cnt <= 0;
        else if (gen_cnt == 24) gen_cnt <= 0;
        else gen_cnt <= gen_cnt + 1;
        if (!rst_n) seen <= 1'b0;
        else if (cpu_clken) seen <= 1'b1;
    end

    // Monitor: compares every cycle against the scoreboard queues and window model.
    always @(negedge clk25) begin
        bit exp_owns;
        ack_exp_t e;
        logic [7:0] rd;
        exp_owns = !seen || (gen_cnt >= 22);
        if (prev_ack_read || dma.rvalid)
            check("rvalid_after_ack", dma.rvalid == (prev_ack_read && rst_n), dma.rvalid, prev_ack_read && rst_n);
        if (dma.ack || dma.rvalid)
            check("ack_rvalid_exclusive", !(dma.ack && dma.rvalid), {dma.ack, dma.rvalid}, 0);
        if (dma.rvalid) begin
            if (rd_q.size() == 0) check("rvalid_unexpected", 1'b0, dma.rdata, 0);
            else begin
                rd = rd_q.pop_front();
                check("rdata", dma.rdata == rd, dma.rdata, rd);
            end
        end
        if (rst_n) begin
            check("cpu_owns", cpu_owns == exp_owns, cpu_owns, exp_owns);
            if (dma.ack) begin
                if (ack_q.size() == 0) check("ack_unexpected", 1'b0, gen_cnt, 0);
                else begin
                    e = ack_q.pop_front();
                    check("ack_phase", seen && gen_cnt == e.phase, gen_cnt, e.phase);
                    check("ack_addr", ram_addr == e.addr, ram_addr, e.addr);
                    check("ack_we", ram_we == e.we, ram_we, e.we);
                    check("ack_din", ram_din == e.din, ram_din, e.din);
                end
            end else if (exp_owns) begin
                check("cpu_addr_mux", ram_addr == cpu_addr, ram_addr, cpu_addr);
                check("cpu_din_mux", ram_din == cpu_din, ram_din, cpu_din);
                check("cpu_we_mux", ram_we == (cpu_we & cpu_cs), ram_we, cpu_we & cpu_cs);
            end else begin
                check("we_blocked", ram_we == 1'b0, ram_we, 0);
            end
            if (cpu_clken && cpu_cs && !cpu_we)
                check("cpu_read_data", ram_dout == exp_cpu_rd, ram_dout, exp_cpu_rd);
        end
        prev_ack_read = dma.ack && !dma.we;
    end

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 80; i++) begin
            step();
            if (seen && gen_cnt == p) return;
        end
        check("wait_phase_timeout", 1'b0, gen_cnt, p);
    endtask

    // One DMA access; returns in the cycle after the ack with req dropped.
    task automatic dma_access(input logic we, input logic [12:0] addr, input logic [7:0] din,
                              input int exp_phase, input logic [7:0] exp_rd);
        ack_exp_t e;
        bit got;
        e.phase = exp_phase; e.we = we; e.addr = addr; e.din = din;
        ack_q.push_back(e);
        if (!we) rd_q.push_back(exp_rd);
        dma.req = 1'b1; dma.we = we; dma.addr = addr; dma.din = din;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk25);
            got = dma.ack;
        end
        if (!got) check("ack_timeout", 1'b0, 0, 1);
        step();
        dma.req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_addr = 13'h0FF; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_din = 8'h00;
        dma.req = 1'b0; dma.we = 1'b0; dma.addr = '0; dma.din = '0;
        repeat (3) step();
        @(negedge clk25);
        check("rst_ack", dma.ack == 1'b0, dma.ack, 0);
        check("rst_rvalid", dma.rvalid == 1'b0, dma.rvalid, 0);
        check("rst_rdata", dma.rdata == 8'h00, dma.rdata, 0);
        check("rst_owns", cpu_owns == 1'b1, cpu_owns, 1);
        check("rst_ram_we", ram_we == 1'b1, ram_we, 1);

        // CPU reads 0x123 with no DMA traffic for two periods.
        step();
        cpu_we = 1'b0; cpu_addr = 13'h123; rst_n = 1'b1; gen_en = 1'b1;
        wait_phase(0);
        wait_phase(0);

        // DMA write then read-back of the top byte.
        wait_phase(3);
        dma_access(1'b1, 13'h1FFF, 8'hA5, 3, 8'h00);
        wait_phase(6);
        dma_access(1'b0, 13'h1FFF, 8'h00, 6, 8'hA5);

        // Request raised inside the CPU window waits for phase 0.
        wait_phase(23);
        dma_access(1'b0, 13'h0123, 8'h00, 0, 8'h5A);

        // Back-to-back reads: acks at 0,2,...,20 then the 12th slips to the next period.
        wait_phase(0);
        for (int i = 0; i < 12; i++)
            dma_access(1'b0, 13'(13'h200 + i), 8'h00, (i < 11) ? 2 * i : 0, 8'(i * 7 + 3));

        // CPU write and DMA write in the same period.
        wait_phase(0);
        cpu_addr = 13'h010; cpu_din = 8'h33; cpu_we = 1'b1;
        wait_phase(5);
        dma_access(1'b1, 13'h011, 8'h44, 5, 8'h00);
        wait_phase(0);
        cpu_we = 1'b0; cpu_addr = 13'h123; cpu_din = 8'h00;
        wait_phase(2);
        dma_access(1'b0, 13'h010, 8'h00, 2, 8'h33);
        dma_access(1'b0, 13'h011, 8'h00, 4, 8'h44);

        // Reset in the cycle after a read ack drops the pending completion.
        wait_phase(10);
        begin
            ack_exp_t e;
            bit got;
            e.phase = 10; e.we = 1'b0; e.addr = 13'h200; e.din = 8'h00;
            ack_q.push_back(e);
            dma.req = 1'b1; dma.we = 1'b0; dma.addr = 13'h200; dma.din = 8'h00;
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk25);
                got = dma.ack;
            end
            if (!got) check("reset_ack_timeout", 1'b0, 0, 1);
        end
        step();
        rst_n = 1'b0; dma.req = 1'b0; gen_en = 1'b0;
        step();
        @(negedge clk25);
        check("rst2_ack", dma.ack == 1'b0, dma.ack, 0);
        check("rst2_rvalid", dma.rvalid == 1'b0, dma.rvalid, 0);
        check("rst2_rdata", dma.rdata == 8'h00, dma.rdata, 0);
        check("rst2_owns", cpu_owns == 1'b1, cpu_owns, 1);
        check("rst2_ram_we", ram_we == 1'b0, ram_we, 0);
        check("rst2_ram_addr", ram_addr == 13'h123, ram_addr, 13'h123);
        step();
        rst_n = 1'b1; gen_en = 1'b1;
        wait_phase(0);
        dma_access(1'b0, 13'h205, 8'h00, 0, 8'd38);

        repeat (5) step();
        check("ack_queue_empty", ack_q.size() == 0, ack_q.size(), 0);
        check("rd_queue_empty", rd_q.size() == 0, rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
